// File: rtl/ysyx_040750_divider.sv
// Radix-2 restoring divider with 64-bit and word (32-bit) modes and signed/unsigned handling.
// Optional macro YSYX_040750_DIV_EARLY_OUT_EN finishes zero-divisor and signed-overflow cases after one BUSY cycle.
module ysyx_040750_divider #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             div_signed,
    input  logic             div_word,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned CW   = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_q, quo_q, dsr_q, spec_q;
    logic             word_q, neg_q_q, neg_r_q, div0_q, ovf_q;

    logic             transfer_c, last_c, early_c, finish_c;
    logic [WIDTH-1:0] a_ext_c, b_ext_c, a_abs_c, b_abs_c;
    logic             a_neg_c, b_neg_c, div0_c, ovf_c;
    logic [WIDTH:0]   shifted_c, diff_c;
    logic             qbit_c;
    logic [WIDTH-1:0] rem_step_c, quo_step_c, q_mag_c, q_sgn_c, r_sgn_c, q_fin_c, r_fin_c;

    assign transfer_c = div_valid & div_ready & ~flush;
    assign last_c     = (cnt == '0);
`ifdef YSYX_040750_DIV_EARLY_OUT_EN
    assign early_c    = div0_q | ovf_q;
`else
    assign early_c    = 1'b0;
`endif
    assign finish_c   = (state == BUSY) & (last_c | early_c);

    // State register; handshake flags are registered copies of the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            div_ready <= 1'b1;
        end else begin
            state     <= state_n;
            out_valid <= (state_n == DONE);
            div_ready <= (state_n == IDLE);
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (transfer_c) state_n = BUSY;
            BUSY:    if (finish_c) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    // Operand preparation: word-mode extension, signs, magnitudes, special cases
    always_comb begin
        a_ext_c = dividend;
        b_ext_c = divisor;
        if (div_word) begin
            a_ext_c = {{HALF{div_signed & dividend[HALF-1]}}, dividend[HALF-1:0]};
            b_ext_c = {{HALF{div_signed & divisor[HALF-1]}}, divisor[HALF-1:0]};
        end
        a_neg_c = div_signed & a_ext_c[WIDTH-1];
        b_neg_c = div_signed & b_ext_c[WIDTH-1];
        a_abs_c = a_neg_c ? -a_ext_c : a_ext_c;
        b_abs_c = b_neg_c ? -b_ext_c : b_ext_c;
        div0_c  = (b_ext_c == '0);
        ovf_c   = div_signed & (a_ext_c == {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} & div_word |
                                a_ext_c == {1'b1, {(WIDTH-1){1'b0}}} & ~div_word) &
                  (b_ext_c == '1);
    end

    // One restoring step plus sign fix-up and special-case override of the final result
    always_comb begin
        shifted_c  = {rem_q, quo_q[WIDTH-1]};
        diff_c     = shifted_c - {1'b0, dsr_q};
        qbit_c     = ~diff_c[WIDTH];
        rem_step_c = qbit_c ? diff_c[WIDTH-1:0] : shifted_c[WIDTH-1:0];
        quo_step_c = {quo_q[WIDTH-2:0], qbit_c};
        q_mag_c    = word_q ? {{HALF{1'b0}}, quo_step_c[HALF-1:0]} : quo_step_c;
        q_sgn_c    = neg_q_q ? -q_mag_c : q_mag_c;
        r_sgn_c    = neg_r_q ? -rem_step_c : rem_step_c;
        q_fin_c    = word_q ? {{HALF{q_sgn_c[HALF-1]}}, q_sgn_c[HALF-1:0]} : q_sgn_c;
        r_fin_c    = word_q ? {{HALF{r_sgn_c[HALF-1]}}, r_sgn_c[HALF-1:0]} : r_sgn_c;
        if (div0_q) begin
            q_fin_c = '1;
            r_fin_c = spec_q;
        end else if (ovf_q) begin
            q_fin_c = spec_q;
            r_fin_c = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            spec_q    <= '0;
            word_q    <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (transfer_c) begin
            cnt     <= div_word ? CW'(HALF - 1) : CW'(WIDTH - 1);
            rem_q   <= '0;
            quo_q   <= div_word ? (a_abs_c << HALF) : a_abs_c;
            dsr_q   <= b_abs_c;
            spec_q  <= div_word ? {{HALF{dividend[HALF-1]}}, dividend[HALF-1:0]} : dividend;
            word_q  <= div_word;
            neg_q_q <= a_neg_c ^ b_neg_c;
            neg_r_q <= a_neg_c;
            div0_q  <= div0_c;
            ovf_q   <= ovf_c;
        end else if (state == BUSY && !flush) begin
            rem_q <= rem_step_c;
            quo_q <= quo_step_c;
            if (!last_c) cnt <= cnt - CW'(1);
            if (finish_c) begin
                quotient  <= q_fin_c;
                remainder <= r_fin_c;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_040750_divider.sv
// Self-checking bench for ysyx_040750_divider: directed corner cases plus randomized operations vs an arithmetic model.
module tb_ysyx_040750_divider;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        div_valid, div_ready, div_signed, div_word, flush, out_valid, out_ready;
    logic [63:0] dividend, divisor, quotient, remainder;
    int          n_checks = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    ysyx_040750_divider #(.WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .div_valid(div_valid), .div_ready(div_ready),
        .dividend(dividend), .divisor(divisor), .div_signed(div_signed), .div_word(div_word),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_special(input logic [63:0] a, input logic [63:0] b, input bit s, input bit w);
        if (w) return (b[31:0] == 32'h0) || (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'h0) || (s && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    // Reference: RISC-V style division semantics computed with native arithmetic
    task automatic ref_div(input logic [63:0] a, input logic [63:0] b, input bit s, input bit w,
                           output logic [63:0] q, output logic [63:0] r);
        logic [31:0] a32, b32, q32, r32;
        int          sa, sb;
        longint      la, lb;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            sa  = a32;
            sb  = b32;
            if (b32 == 32'h0) begin
                q32 = '1;
                r32 = a32;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32;
                r32 = 32'h0;
            end else if (s) begin
                q32 = sa / sb;
                r32 = sa % sb;
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            la = a;
            lb = b;
            if (b == 64'h0) begin
                q = '1;
                r = a;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a;
                r = 64'h0;
            end else if (s) begin
                q = la / lb;
                r = la % lb;
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input bit s, input bit w, input int hold);
        logic [63:0] eq, er;
        int          exp_lat, lat;
        ref_div(a, b, s, w, eq, er);
        exp_lat = w ? 33 : 65;
`ifdef YSYX_040750_DIV_EARLY_OUT_EN
        if (is_special(a, b, s, w)) exp_lat = 2;
`endif
        check_eq("ready_idle", 64'(div_ready), 64'd1);
        dividend = a; divisor = b; div_signed = s; div_word = w; div_valid = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
        div_signed = 1'($urandom); div_word = 1'($urandom);
        lat = 1;
        check_eq("ready_busy", 64'(div_ready), 64'd0);
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", 64'(lat), 64'(exp_lat));
        check_eq("quotient", quotient, eq);
        check_eq("remainder", remainder, er);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_ready", 64'(div_ready), 64'd0);
            check_eq("hold_quot", quotient, eq);
            check_eq("hold_rem", remainder, er);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("valid_drop", 64'(out_valid), 64'd0);
        check_eq("ready_back", 64'(div_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] a, b;
        bit          s, w;
        int          sel;
        rst_n = 1'b0; div_valid = 1'b0; dividend = '0; divisor = '0;
        div_signed = 1'b0; div_word = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_quot", quotient, 64'd0);
        check_eq("rst_rem", remainder, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_ready", 64'(div_ready), 64'd1);

        run_op(64'd100, 64'd7, 1'b0, 1'b0, 0);
        run_op(-64'sd7, 64'd2, 1'b1, 1'b0, 0);
        run_op(64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 0);
        run_op(64'd5, 64'd0, 1'b0, 1'b0, 0);
        run_op(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 0);
        run_op(64'hDEAD_BEEF_8000_0005, 64'h1234_5678_0000_0000, 1'b1, 1'b1, 0);
        run_op(64'd1000, 64'd3, 1'b0, 1'b0, 5);

        // Flush mid-operation, with a competing request in the flush cycle
        dividend = 64'd50; divisor = 64'd5; div_signed = 1'b0; div_word = 1'b0; div_valid = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1; div_valid = 1'b1; dividend = 64'd77; divisor = 64'd7;
        @(posedge clk); #1;
        flush = 1'b0; div_valid = 1'b0;
        check_eq("flush_valid", 64'(out_valid), 64'd0);
        check_eq("flush_ready", 64'(div_ready), 64'd1);
        repeat (70) @(posedge clk);
        #1;
        check_eq("flush_no_result", 64'(out_valid), 64'd0);
        run_op(64'd9, 64'd3, 1'b0, 1'b0, 0);

        // Flush while a result waits in DONE
        dividend = 64'd20; divisor = 64'd4; div_valid = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0;
        repeat (66) @(posedge clk);
        #1;
        check_eq("done_before_flush", 64'(out_valid), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("done_flush_valid", 64'(out_valid), 64'd0);
        check_eq("done_flush_ready", 64'(div_ready), 64'd1);

        // Reset mid-operation discards the work
        dividend = 64'd123; divisor = 64'd4; div_valid = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check_eq("midrst_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_quot", quotient, 64'd0);
        rst_n = 1'b1;
        repeat (70) @(posedge clk);
        #1;
        check_eq("midrst_no_result", 64'(out_valid), 64'd0);
        check_eq("midrst_ready", 64'(div_ready), 64'd1);

        for (int t = 0; t < 80; t++) begin
            s   = 1'($urandom);
            w   = 1'($urandom);
            a   = {$urandom, $urandom};
            sel = $urandom_range(0, 9);
            case (sel)
                0:       b = '0;
                1:       b = '1;
                2, 3:    b = 64'($urandom_range(1, 255));
                4:       b = {32'h0, $urandom};
                default: b = {$urandom, $urandom};
            endcase
            if (sel == 1 && $urandom_range(0, 1) == 1)
                a = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
            run_op(a, b, s, w, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
